// File: rtl/div_seq_nbit.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// with a Start/Busy/Done handshake and divide-by-zero / fractional flags.
module div_seq_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Error,
    output logic             Fractional
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd, dvs, rem, quo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_shift, r_diff;
    logic             fit;
    logic [WIDTH-1:0] rem_step, quo_step;

    // One restoring step; rem < dvs keeps r_shift < 2*dvs, so both outcomes fit WIDTH bits.
    always_comb begin
        r_shift       = {rem, dvd[cnt]};
        r_diff        = r_shift - {1'b0, dvs};
        fit           = (r_shift >= {1'b0, dvs});
        rem_step      = fit ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        quo_step      = quo;
        quo_step[cnt] = fit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                Done = (state == DONE);
                if (Start) state_next = (B == '0) ? DONE : CALC;
                else       state_next = IDLE;
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            Quotient   <= '0;
            Remainder  <= '0;
            Error      <= 1'b0;
            Fractional <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        if (B != '0) begin
                            dvd <= A;
                            dvs <= B;
                            rem <= '0;
                            quo <= '0;
                            cnt <= CW'(WIDTH - 1);
                        end else begin
                            Quotient   <= '0;
                            Remainder  <= '0;
                            Error      <= 1'b1;
                            Fractional <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    if (cnt == '0) begin
                        Quotient   <= quo_step;
                        Remainder  <= rem_step;
                        Error      <= 1'b0;
                        Fractional <= |rem_step;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_nbit.sv
// Directed bench for div_seq_nbit: a WIDTH=4 and a WIDTH=8 instance checked
// cycle by cycle against hand-computed quotients, remainders and flags.
module tb_div_seq_nbit;

    logic       clk;
    logic       rst4_n, rst8_n;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, err4, frac4;
    logic       busy8, done8, err8, frac8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;

    int checks = 0;
    int errors = 0;

    div_seq_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .Start(start4), .A(a4), .B(b4),
        .Busy(busy4), .Done(done4), .Quotient(q4), .Remainder(r4),
        .Error(err4), .Fractional(frac4)
    );

    div_seq_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .Start(start8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .Quotient(q8), .Remainder(r8),
        .Error(err8), .Fractional(frac8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res4(input string tag, input int q, input int r, input int e, input int f);
        check({tag, " Q"}, 32'(q4), 32'(q));
        check({tag, " R"}, 32'(r4), 32'(r));
        check({tag, " Err"}, 32'(err4), 32'(e));
        check({tag, " Frac"}, 32'(frac4), 32'(f));
    endtask

    // Accept a non-zero divide in cycle 0, check Busy in 1..4 and Done in 5.
    task automatic run4(input string tag, input int a, input int b, input int q, input int r);
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check({tag, " busy"}, 32'(busy4), 32'd1);
            check({tag, " done early"}, 32'(done4), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(done4), 32'd1);
        check({tag, " busy at done"}, 32'(busy4), 32'd0);
        res4(tag, q, r, 0, (r != 0) ? 1 : 0);
    endtask

    task automatic run8(input string tag, input int a, input int b, input int q, input int r);
        a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check({tag, " busy"}, 32'(busy8), 32'd1);
            check({tag, " done early"}, 32'(done8), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(done8), 32'd1);
        check({tag, " Q"}, 32'(q8), 32'(q));
        check({tag, " R"}, 32'(r8), 32'(r));
        check({tag, " Err"}, 32'(err8), 32'd0);
        check({tag, " Frac"}, 32'(frac8), (r != 0) ? 32'd1 : 32'd0);
        tick();
    endtask

    initial begin
        rst4_n = 1'b0; rst8_n = 1'b0;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        #2;
        check("rst busy", 32'(busy4), 32'd0);
        check("rst done", 32'(done4), 32'd0);
        res4("rst", 0, 0, 0, 0);
        rst4_n = 1'b1; rst8_n = 1'b1;
        tick();

        run4("13/4", 13, 4, 3, 1);
        tick();
        check("idle after done", 32'(done4), 32'd0);
        check("idle busy", 32'(busy4), 32'd0);
        check("hold Q", 32'(q4), 32'd3);

        // Back-to-back: new Start during the Done cycle.
        run4("12/3", 12, 3, 4, 0);
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("b2b done drops", 32'(done4), 32'd0);
        check("b2b busy", 32'(busy4), 32'd1);
        check("b2b hold Q", 32'(q4), 32'd4);
        for (int c = 2; c <= 5; c++) tick();
        check("15/15 done", 32'(done4), 32'd1);
        res4("15/15", 1, 0, 0, 0);
        tick();

        // Divide by zero, then a re-entry of DONE via another zero divisor.
        a4 = 4'd7; b4 = 4'd0; start4 = 1'b1;
        tick();
        check("7/0 done", 32'(done4), 32'd1);
        check("7/0 busy", 32'(busy4), 32'd0);
        res4("7/0", 0, 0, 1, 0);
        a4 = 4'd5;
        tick();
        start4 = 1'b0;
        check("5/0 done again", 32'(done4), 32'd1);
        check("5/0 busy", 32'(busy4), 32'd0);
        check("5/0 Err", 32'(err4), 32'd1);
        tick();
        check("after 0div idle", 32'(done4), 32'd0);
        run4("9/2", 9, 2, 4, 1);
        tick();

        // Start and operand changes during CALC must be ignored.
        a4 = 4'd6; b4 = 4'd5; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = 4'd15; b4 = 4'd1;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = 4'd2; b4 = 4'd3;
        tick(); tick();
        check("6/5 done", 32'(done4), 32'd1);
        res4("6/5", 1, 1, 0, 1);
        tick();
        check("no queued op busy", 32'(busy4), 32'd0);
        check("no queued op done", 32'(done4), 32'd0);

        // Asynchronous reset in cycle 3 of 14/3.
        a4 = 4'd14; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(); tick();
        #2;
        rst4_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy4), 32'd0);
        check("async rst done", 32'(done4), 32'd0);
        res4("async rst", 0, 0, 0, 0);
        tick();
        rst4_n = 1'b1;
        tick();
        check("post rst idle", 32'(busy4), 32'd0);
        run4("14/3", 14, 3, 4, 2);
        tick();

        run8("200/7", 200, 7, 28, 4);
        run8("255/1", 255, 1, 255, 0);
        run8("3/200", 3, 200, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: got no finish, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_seq_nbit.md
# div_seq_nbit

Parametrised sequential unsigned divider, the next generation of the 4-bit combinational divider in the ALU datapath. It computes Quotient and Remainder for any divisor, not only selected ones, using radix-2 restoring division with one quotient bit per clock. It keeps the existing Error (divide-by-zero) and Fractional (non-zero remainder) flags and adds a Start/Busy/Done handshake so the ALU can sequence it.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; accepted only in IDLE or DONE.
- A  input  WIDTH  dividend (unsigned), sampled on the accepting edge.
- B  input  WIDTH  divisor (unsigned), sampled on the accepting edge.
- Busy  output  1  high while in CALC.
- Done  output  1  one-cycle pulse; results valid from this cycle.
- Quotient  output  WIDTH  floor(A/B).
- Remainder  output  WIDTH  A mod B.
- Error  output  1  divisor was zero.
- Fractional  output  1  Remainder != 0 and Error = 0.

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- Reset values: Busy=0, Done=0, Quotient=0, Remainder=0, Error=0, Fractional=0, internal counter=0.
- IDLE/DONE with Start=1, B!=0:
  - Latch A and B.
  - Clear the partial remainder.
  - Set counter=WIDTH-1.
  - Go to CALC.
- IDLE/DONE with Start=1, B=0:
  - Go directly to DONE.
  - Set Quotient=0, Remainder=0, Error=1, Fractional=0.
- IDLE/DONE with Start=0: DONE returns to IDLE. Outputs hold.
- CALC, each edge:
  - Form R' = {R[WIDTH-1:0], dividend bit[counter]}, using WIDTH+1 bits internally.
  - If R' >= divisor: R = R' - divisor and quotient bit[counter] = 1. Otherwise R = R' and the bit = 0.
  - At counter=0: go to DONE and load Quotient/Remainder from the working registers, with Error=0 and Fractional = |Remainder. Otherwise decrement the counter.
- Start in CALC is ignored, with no queueing. A/B changes during CALC have no effect.
- Result outputs (Quotient, Remainder, Error, Fractional) hold their values until the next DONE entry. They are not cleared on acceptance of a new Start.
- Arithmetic is unsigned only. No overflow is possible: Quotient fits WIDTH bits and Remainder < B.

## Timing
- Cycle 0: Start=1 sampled at the end of cycle 0 in IDLE.
- Normal divide:
  - Busy=1 for cycles 1..WIDTH.
  - Done=1 and results updated in cycle WIDTH+1.
  - Latency from the accepting edge to Done is WIDTH+1 edges.
- Divide by zero: Done=1 and Error=1 in cycle 1, with Busy never asserted.
- Back-to-back: Start=1 during a Done cycle is accepted. Done drops and Busy rises the next cycle, for a throughput of one result per WIDTH+1 cycles.
- Done is high for exactly one cycle unless a new divide-by-zero is accepted in DONE, which re-enters DONE and keeps Done high for another cycle.
- Reset asserted mid-CALC: all outputs go to their reset values immediately (asynchronously) and the FSM returns to IDLE. After rst_n rises, the first Start is treated as a fresh operation.
- rst_n deassertion is synchronised externally. The block does not need to handle deassertion near a clock edge.

## Test plan
- WIDTH=4, A=13, B=4, Start in cycle 0 -> Busy cycles 1-4; cycle 5: Done=1, Quotient=3, Remainder=1, Fractional=1, Error=0.
- WIDTH=4, 12/3 then Start again in its Done cycle with 15/15 -> first Done: Q=4, R=0, Fractional=0. Second Done 5 cycles later: Q=1, R=0.
- WIDTH=4, A=7, B=0 -> cycle 1: Done=1, Error=1, Q=0, R=0, Fractional=0, Busy stays 0. A following 9/2 gives Q=4, R=1, Error=0.
- WIDTH=4, 6/5 started, Start pulsed with 15/1 in cycle 2 and A/B changed during CALC -> the pulse is ignored; cycle 5 gives Q=1, R=1.
- WIDTH=4, rst_n low in cycle 3 of 14/3 -> all outputs 0 without waiting for a clock edge, FSM in IDLE. After release, 14/3 completes with Q=4, R=2.
- WIDTH=8, A=200, B=7 -> Done in cycle 9 with Q=28, R=4, Fractional=1. Also 255/1 gives Q=255, R=0, and 3/200 gives Q=0, R=3.
